// File: rtl/hippo_lsu.sv
// Load/store unit: one outstanding access on a req/gnt/rvalid bus, with store lane
// steering, load extension, a REQ+WAIT timeout and RVFI memory reporting.
module hippo_lsu #(
  parameter int TimeoutCycles = 16
) (
  input  logic        i_clk,
  input  logic        rst_i,
  input  logic        i_valid,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wmask,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_rvfi_mem_addr,
  output logic [3:0]  o_rvfi_mem_rmask,
  output logic [3:0]  o_rvfi_mem_wmask,
  output logic [31:0] o_rvfi_mem_rdata,
  output logic [31:0] o_rvfi_mem_wdata
);

  localparam int CntW = $clog2(TimeoutCycles + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic            op_load, op_store, op_err;
  logic [2:0]      op_funct3;
  logic [31:0]     op_addr, op_wdata, bus_word;
  logic [CntW-1:0] cnt;

  logic        accept, bad_op, timeout, capture, err_set, report;
  logic [1:0]  off;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata, word_addr;

  function automatic logic funct3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load)
      return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
             (f3 == 3'b100) || (f3 == 3'b101);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

  function automatic logic [3:0] mask_of(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word,
                                              input logic [1:0] lane);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign accept  = (state == IDLE) && i_valid && (i_load || i_store);
  assign bad_op  = (i_load && i_store) || !funct3_legal(i_load, i_funct3) ||
                   misaligned(i_funct3, i_addr[1:0]);
  assign timeout = (cnt == CntW'(TimeoutCycles - 1));

  assign off        = op_addr[1:0];
  assign word_addr  = {op_addr[31:2], 2'b00};
  assign lane_mask  = mask_of(op_funct3, off);
  assign lane_wdata = replicate(op_funct3, op_wdata);

  always_ff @(posedge i_clk or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // A completing gnt/rvalid wins over a timeout landing in the same cycle.
  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    err_set     = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wmask = '0;
    o_mem_wdata = '0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = bad_op ? DONE : REQ;
      end
      REQ: begin
        o_mem_req   = 1'b1;
        o_mem_we    = op_store;
        o_mem_addr  = word_addr;
        o_mem_wmask = op_store ? lane_mask : 4'b0000;
        o_mem_wdata = op_store ? lane_wdata : 32'd0;
        if (i_mem_gnt && op_store) begin
          state_nxt = DONE;
        end else if (i_mem_gnt && i_mem_rvalid) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end else if (timeout) begin
          state_nxt = DONE;
          err_set   = 1'b1;
        end else if (i_mem_gnt) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (i_mem_rvalid) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end else if (timeout) begin
          state_nxt = DONE;
          err_set   = 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_i) begin
    if (!rst_i) begin
      op_load   <= 1'b0;
      op_store  <= 1'b0;
      op_err    <= 1'b0;
      op_funct3 <= '0;
      op_addr   <= '0;
      op_wdata  <= '0;
      bus_word  <= '0;
      cnt       <= '0;
    end else if (accept) begin
      op_load   <= i_load;
      op_store  <= i_store;
      op_err    <= bad_op;
      op_funct3 <= i_funct3;
      op_addr   <= i_addr;
      op_wdata  <= i_wdata;
      bus_word  <= '0;
      cnt       <= '0;
    end else begin
      if ((state == REQ) || (state == WAIT)) cnt <= cnt + CntW'(1);
      if (capture) bus_word <= i_mem_rdata;
      if (err_set) op_err <= 1'b1;
    end
  end

  // Reset gating keeps the stall low while an instruction is presented during reset.
  assign o_stall = rst_i && (accept || (state == REQ) || (state == WAIT));
  assign o_done  = (state == DONE);
  assign o_err   = o_done && op_err;
  assign report  = o_done && !op_err;
  assign o_rdata = (report && op_load) ? load_extend(op_funct3, bus_word, off) : 32'd0;

  assign o_rvfi_mem_addr  = report ? word_addr : 32'd0;
  assign o_rvfi_mem_rmask = (report && op_load) ? lane_mask : 4'b0000;
  assign o_rvfi_mem_wmask = (report && op_store) ? lane_mask : 4'b0000;
  assign o_rvfi_mem_rdata = (report && op_load) ? bus_word : 32'd0;
  assign o_rvfi_mem_wdata = (report && op_store) ? lane_wdata : 32'd0;

endmodule
